// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron bank: default sizing,
// a width-aware saturating adder and the flattened-bus channel slice offset.
package lif_pkg;

    localparam int unsigned W_DEF          = 8;
    localparam int unsigned LEAK_SHIFT_DEF = 3;
    localparam int unsigned REFRAC_CYC_DEF = 4;

    // Unsigned add clamped to 2^width-1; valid for width up to 32.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << width) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/lif_neuron_bank_update.sv
// Combinational single-channel LIF update: leak, saturating integrate,
// threshold compare and refractory countdown. Adaptive threshold under LIF_NB_ADAPT_EN.
module lif_update
    import lif_pkg::*;
#(
    parameter int unsigned W           = W_DEF,
    parameter int unsigned LEAK_SHIFT  = LEAK_SHIFT_DEF,
    parameter int unsigned REFRAC_CYC  = REFRAC_CYC_DEF,
    parameter int unsigned RW          = 3,
    parameter int unsigned ADAPT_INC   = 4,
    parameter int unsigned ADAPT_SHIFT = 2
) (
    input  logic [W-1:0]  v,
    input  logic [RW-1:0] rcnt,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  i_ext,
    input  logic [W-1:0]  thresh,
    output logic [W-1:0]  v_next,
    output logic [RW-1:0] rcnt_next,
    output logic [W-1:0]  a_next,
    output logic          fire
);

    logic [W-1:0] leaked;
    logic [W-1:0] vn;
    logic [W-1:0] th_eff;
    logic [W-1:0] a_decay;
    logic [W-1:0] a_bumped;

    // Leak term is never larger than v, so the subtraction cannot wrap.
    assign leaked   = v - (v >> LEAK_SHIFT);
    assign vn       = W'(sat_add(32'(leaked), 32'(i_ext), W));
    assign a_decay  = a - (a >> ADAPT_SHIFT);
    assign a_bumped = W'(sat_add(32'(a_decay), 32'(ADAPT_INC), W));

`ifdef LIF_NB_ADAPT_EN
    assign th_eff = W'(sat_add(32'(thresh), 32'(a), W));
`else
    assign th_eff = thresh;
`endif

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        v_next    = vn;
        rcnt_next = rcnt;
        a_next    = a_decay;
        fire      = 1'b0;
        if (rcnt != '0) begin
            v_next    = '0;
            rcnt_next = rcnt - RW'(1);
        end else if (vn >= th_eff) begin
            fire      = 1'b1;
            v_next    = '0;
            rcnt_next = RW'(REFRAC_CYC);
            a_next    = a_bumped;
        end
    end

endmodule

// File: rtl/lif_neuron_bank.sv
// Time-multiplexed bank of N_CH LIF neurons sharing one lif_update datapath,
// serviced round-robin. Optional adaptive threshold: define LIF_NB_ADAPT_EN.
module lif_neuron_bank
    import lif_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned W           = W_DEF,
    parameter int unsigned LEAK_SHIFT  = LEAK_SHIFT_DEF,
    parameter int unsigned REFRAC_CYC  = REFRAC_CYC_DEF,
    parameter int unsigned ADAPT_INC   = 4,
    parameter int unsigned ADAPT_SHIFT = 2,
    localparam int unsigned CW         = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [N_CH*W-1:0] i_ext,
    input  logic [W-1:0]      thresh,
    output logic [N_CH-1:0]   spike,
    output logic [N_CH*W-1:0] voltage,
    output logic [CW-1:0]     ch_idx,
    output logic              frame_done
);

    // A refractory length of 0 still needs a 1-bit counter that stays at zero.
    localparam int unsigned RW = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    logic [W-1:0]  v_q    [N_CH];
    logic [RW-1:0] rcnt_q [N_CH];
    logic [W-1:0]  i_cur;
    logic [W-1:0]  a_cur;
    logic [W-1:0]  v_next;
    logic [RW-1:0] rcnt_next;
    logic [W-1:0]  a_next;
    logic          fire;

    assign i_cur = i_ext[ch_lsb(ch_idx, W) +: W];

`ifdef LIF_NB_ADAPT_EN
    logic [W-1:0] a_q [N_CH];
    assign a_cur = a_q[ch_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) a_q[k] <= '0;
        end else if (en) begin
            a_q[ch_idx] <= a_next;
        end
    end
`else
    logic [W-1:0] a_next_unused;
    assign a_cur         = '0;
    assign a_next_unused = a_next;
`endif

    lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC_CYC (REFRAC_CYC),
        .RW         (RW),
        .ADAPT_INC  (ADAPT_INC),
        .ADAPT_SHIFT(ADAPT_SHIFT)
    ) u_update (
        .v        (v_q[ch_idx]),
        .rcnt     (rcnt_q[ch_idx]),
        .a        (a_cur),
        .i_ext    (i_cur),
        .thresh   (thresh),
        .v_next   (v_next),
        .rcnt_next(rcnt_next),
        .a_next   (a_next),
        .fire     (fire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the state arrays are plain flops (N_CH entries), so they are reset, unlike a RAM.
            for (int k = 0; k < N_CH; k++) begin
                v_q[k]    <= '0;
                rcnt_q[k] <= '0;
            end
            ch_idx     <= '0;
            spike      <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so the default clear and the indexed set resolve last-wins.
            spike      <= '0;
            frame_done <= 1'b0;
            if (en) begin
                v_q[ch_idx]    <= v_next;
                rcnt_q[ch_idx] <= rcnt_next;
                spike[ch_idx]  <= fire;
                frame_done     <= (ch_idx == LAST_CH);
                ch_idx         <= (ch_idx == LAST_CH) ? '0 : ch_idx + CW'(1);
            end
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_volt
        assign voltage[ch_lsb(k, W) +: W] = v_q[k];
    end

endmodule
